stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- LIFO operand stack for the multicycle stack-machine datapath. It is the responder to the controller's push/pop/tos command strobes.
- The controller asserts at most a few strobes per instruction. The stack answers with a registered top-of-stack value, one cycle after the command, for A-register capture, the ALU or the JZ test.
- It also reports occupancy and sticky overflow/underflow error flags for debug and testbench checking.

Parameters:
- DATA_WIDTH, 8, width of each stack entry and of din/dout.
- DEPTH, 8, number of entries. Must be a power of 2 and at least 2.
- PTR_WIDTH, $clog2(DEPTH)+1, width of the stack pointer/count. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  write din on top of stack this cycle.
- pop  input  1  remove top entry; the entry appears on dout next cycle.
- tos  input  1  copy top entry to dout next cycle without removing it.
- clr  input  1  synchronous flush: count := 0, error flags cleared.
- din  input  DATA_WIDTH  push data (ALU result or memory read data).
- dout  output  DATA_WIDTH  registered top-of-stack result.
- count  output  PTR_WIDTH  current number of valid entries (0..DEPTH).
- empty  output  1  count == 0 (combinational from count).
- full  output  1  count == DEPTH (combinational from count).
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop or tos was rejected.

Behaviour:
- Reset (rst low, async):
  - count = 0, dout = 0, overflow = 0, underflow = 0.
  - Storage array is not reset.
  - Strobes are ignored while reset is asserted; operation resumes on the first clk edge after rst rises.
- Storage is DEPTH x DATA_WIDTH registers. The top entry is mem[count-1]; the next push slot is mem[count].
- Commands are evaluated on each rising edge with this priority:
  1. clr
  2. push&pop (replace)
  3. pop
  4. push
  5. tos
- clr: count := 0, overflow := 0, underflow := 0. dout holds its value. Any other strobe in the same cycle is ignored.
- pop only:
  - If not empty: dout := mem[count-1], count := count-1.
  - If empty: count unchanged, dout holds, underflow := 1.
- tos only (or tos+push, see below):
  - If not empty: dout := mem[count-1], count unchanged.
  - If empty: dout holds, underflow := 1.
- push only:
  - If not full: mem[count] := din, count := count+1. dout unchanged.
  - If full: no write, count unchanged, overflow := 1.
- push & pop together:
  - If not empty: dout := mem[count-1] (old top), mem[count-1] := din, count unchanged. This replace operation is legal even when full.
  - If empty: treated as push only, and underflow := 1.
- tos with pop: pop wins; tos is ignored.
- tos with push (no pop):
  - dout := pre-push top, or holds if empty (underflow := 1).
  - The push proceeds under the push-only rules.
- Latency:
  - dout is valid the cycle after a pop/tos strobe, and remains stable until the next successful pop/tos/replace.
  - Consecutive pops on back-to-back cycles are supported: each following cycle shows the next-lower entry. The controller relies on this for its two-operand pop sequence followed by the A-register write.
- A write and a read of the same address in the same cycle use the pre-edge contents; there is no bypass of din to dout.
- Flags:
  - empty and full are combinational from count.
  - overflow and underflow are sticky until clr or reset.
  - Error cycles never corrupt count, mem or dout.
- No internal FSM beyond the count register. All state is count, dout, the flags and mem.

Test Plan:
- Reset with rst low mid-run after 3 pushes -> count=0, dout=0, empty=1, flags 0. Push 8'h11 after release -> count=1.
- Push 8'h05, push 8'h09, then pop on two consecutive cycles -> dout=8'h09 in the first cycle after, 8'h05 in the second. Count goes 2->1->0; empty=1 at the end.
- Push 8 values 8'h01..8'h08 -> full=1, count=8. Push 8'hFF -> overflow=1, count stays 8. A following pop returns 8'h08.
- Pop or tos while empty -> underflow=1, dout unchanged, count=0. clr -> underflow=0.
- Push 8'h0A, then tos -> dout=8'h0A, count=1. Assert push&pop with din=8'h3C -> dout=8'h0A, count=1. Next pop -> dout=8'h3C.
- Fill to DEPTH, then push&pop with din=8'h77 -> no overflow, count=8. Pop -> dout=8'h77. Assert clr together with push -> count=0, no write.

Source files
------------

// File: rtl/stack_unit.sv
// LIFO operand stack for the multicycle stack-machine datapath.
// Answers push/pop/tos/clr strobes with a registered top-of-stack and sticky error flags.

module stack_unit #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 8,
  localparam int unsigned PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  tos,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("stack_unit: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] w_top_idx;
  logic [ADDR_WIDTH-1:0] w_push_idx;
  logic [DATA_WIDTH-1:0] w_top;
  logic                  w_rd_req;

  logic [PTR_WIDTH-1:0]  w_count_nxt;
  logic [DATA_WIDTH-1:0] w_dout_nxt;
  logic                  w_overflow_nxt;
  logic                  w_underflow_nxt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_wr_idx;

  // Occupancy decode and top-of-stack read (pre-edge contents, no din bypass).
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == PTR_WIDTH'(DEPTH));
  assign w_top_idx  = ADDR_WIDTH'(r_count - PTR_WIDTH'(1));
  assign w_push_idx = ADDR_WIDTH'(r_count);
  assign w_top      = r_mem[w_top_idx];
  assign w_rd_req   = pop | tos;

  // Command decode: clr > replace > pop > push; tos only drives the read path.
  always_comb begin
    w_count_nxt     = r_count;
    w_dout_nxt      = r_dout;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    w_we            = 1'b0;
    w_wr_idx        = w_push_idx;

    if (clr) begin
      w_count_nxt     = '0;
      w_overflow_nxt  = 1'b0;
      w_underflow_nxt = 1'b0;
    end else begin
      if (w_rd_req) begin
        if (w_empty) begin
          w_underflow_nxt = 1'b1;
        end else begin
          w_dout_nxt = w_top;
        end
      end

      if (push && pop && !w_empty) begin
        w_we     = 1'b1;
        w_wr_idx = w_top_idx;
      end else if (pop && !push) begin
        if (!w_empty) begin
          w_count_nxt = r_count - PTR_WIDTH'(1);
        end
      end else if (push) begin
        if (w_full) begin
          w_overflow_nxt = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_count_nxt = r_count + PTR_WIDTH'(1);
        end
      end
    end
  end

  // Control state; storage below is left unreset since slots above count are never read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_dout      <= w_dout_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  assign dout      = r_dout;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign empty     = w_empty;
  assign full      = w_full;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: queue-based reference stack feeding a scoreboard
// of expected post-edge outputs, compared one cycle after each command.

module tb_stack_unit;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PW-1:0] count;
    logic [DW-1:0] dout;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic          tos;
  logic          clr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  exp_t          sb_q[$];
  logic [DW-1:0] m_stack[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  int n_checks;
  int n_errors;

  stack_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .tos      (tos),
    .clr      (clr),
    .din      (din),
    .dout     (dout),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference LIFO behaviour for one clock edge.
  task automatic model_step(input logic p_push, input logic p_pop, input logic p_tos,
                            input logic p_clr, input logic [DW-1:0] p_din);
    exp_t e;
    int   sz;
    sz = m_stack.size();
    if (p_clr) begin
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p_push && p_pop && sz > 0) begin
      m_dout          = m_stack[sz-1];
      m_stack[sz-1]   = p_din;
    end else begin
      if (p_pop || p_tos) begin
        if (sz == 0) m_unf = 1'b1;
        else         m_dout = m_stack[sz-1];
      end
      if (p_pop && !p_push) begin
        if (sz > 0) void'(m_stack.pop_back());
      end else if (p_push) begin
        if (sz == int'(DEPTH)) m_ovf = 1'b1;
        else                   m_stack.push_back(p_din);
      end
    end
    e.count = PW'(m_stack.size());
    e.dout  = m_dout;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, no expectation for observed count %0d", tag, count);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".count"}, 32'(count), 32'(e.count));
      check({tag, ".dout"},  32'(dout),  32'(e.dout));
      check({tag, ".empty"}, 32'(empty), 32'(e.count == '0));
      check({tag, ".full"},  32'(full),  32'(e.count == PW'(DEPTH)));
      check({tag, ".ovf"},   32'(overflow),  32'(e.ovf));
      check({tag, ".unf"},   32'(underflow), 32'(e.unf));
    end
  endtask

  // Drive one command, advance one edge, compare against the scoreboard.
  task automatic step(input string tag, input logic p_push, input logic p_pop,
                      input logic p_tos, input logic p_clr, input logic [DW-1:0] p_din);
    push = p_push;
    pop  = p_pop;
    tos  = p_tos;
    clr  = p_clr;
    din  = p_din;
    model_step(p_push, p_pop, p_tos, p_clr, p_din);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
    clr  = 1'b0;
    compare_out(tag);
  endtask

  task automatic do_push(input string tag, input logic [DW-1:0] d);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(0));
    check({tag, ".dout"},  32'(dout),  32'(0));
    check({tag, ".empty"}, 32'(empty), 32'(1));
    check({tag, ".ovf"},   32'(overflow),  32'(0));
    check({tag, ".unf"},   32'(underflow), 32'(0));
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
    clr  = 1'b0;
    din  = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    rst = 1'b1;

    // Mid-run reset after three pushes, with a strobe held during reset.
    do_push("pre_rst0", 8'hA1);
    do_push("pre_rst1", 8'hA2);
    do_push("pre_rst2", 8'hA3);
    rst = 1'b0;
    model_reset();
    #2;
    check_reset_state("midrst");
    push = 1'b1;
    din  = 8'h55;
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    push = 1'b0;
    rst  = 1'b1;
    do_push("post_rst", 8'h11);

    // Back-to-back pops.
    step("clr0", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    do_push("b2b_push0", 8'h05);
    do_push("b2b_push1", 8'h09);
    step("b2b_pop0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("b2b_pop1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Fill, overflow, pop.
    for (int i = 1; i <= int'(DEPTH); i++) do_push("fill", DW'(i));
    do_push("ovf_push", 8'hFF);
    step("ovf_pop", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Underflow on empty pop/tos, then clr.
    step("clr1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step("unf_pop", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("unf_tos", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("unf_clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // tos, replace, pop.
    do_push("rep_push", 8'h0A);
    step("rep_tos", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("rep_pp",  1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    step("rep_pop", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Replace while full, then clr with push.
    for (int i = 0; i < int'(DEPTH); i++) do_push("fill2", DW'(8'h20 + i));
    step("full_rep", 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    step("full_pop", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("clr_push", 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);

    // Corner mixes: push&pop on empty, tos with push, tos with pop.
    step("pp_empty", 1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
    step("tos_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'h43);
    step("tos_pop",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    // Random command mix.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 35),
           1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 3),
           DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
